// File: rtl/lfm_seq_if.sv
// lfm_seq_if: parameter/strobe bundle between lfm_chirp_sequencer (master)
// and dds_lfm (slave).
//
// Handshake: `start` is a one-cycle strobe from the sequencer. f_start, f_stop
// and chirp_len are already valid in the cycle `start` is high, and they stay
// stable until the sequencer loads the next profile. `dds_done` may be a pulse
// or a held level. The sequencer only reacts to its rising edge while it is
// waiting for the chirp to finish.
interface lfm_seq_if;
  logic [31:0] f_start;
  logic [31:0] f_stop;
  logic [63:0] chirp_len;
  logic        start;
  logic        dds_done;

  modport master (
    output f_start,
    output f_stop,
    output chirp_len,
    output start,
    input  dds_done
  );

  modport slave (
    input  f_start,
    input  f_stop,
    input  chirp_len,
    input  start,
    output dds_done
  );
endinterface

// File: rtl/lfm_chirp_sequencer.sv
// lfm_chirp_sequencer: steps dds_lfm through a table of chirp profiles.
// The sequencer fires each active profile in turn and inserts that profile's
// gap after its done. It repeats the whole pattern repeat_count times, or
// forever when repeat_count is 0.
// Optional feature macro: LFM_SEQ_TIMEOUT_EN adds a WAIT-state watchdog that
// drives the sticky `timeout` flag. Without the macro, `timeout` is tied to 0.
module lfm_chirp_sequencer #(
  parameter int N_PROFILES     = 4,
  parameter int PROF_BITS      = 2,
  parameter int GAP_WIDTH      = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_MARGIN = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [PROF_BITS-1:0] cfg_addr,
  input  logic [31:0]          cfg_f_start,
  input  logic [31:0]          cfg_f_stop,
  input  logic [63:0]          cfg_len,
  input  logic [GAP_WIDTH-1:0] cfg_gap,
  input  logic [PROF_BITS:0]   n_active,
  input  logic [CNT_WIDTH-1:0] repeat_count,
  input  logic                 run,
  input  logic                 abort,
  lfm_seq_if.master            dds,
  output logic                 busy,
  output logic                 seq_done,
  output logic [PROF_BITS-1:0] profile_idx,
  output logic [CNT_WIDTH-1:0] pass_cnt,
  output logic                 timeout,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_FIRE = 3'd2,
    S_WAIT = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  localparam logic [PROF_BITS:0] N_PROF_L = (PROF_BITS + 1)'(N_PROFILES);

  state_t state;

  logic [31:0]          tbl_f_start [N_PROFILES];
  logic [31:0]          tbl_f_stop  [N_PROFILES];
  logic [63:0]          tbl_len     [N_PROFILES];
  logic [GAP_WIDTH-1:0] tbl_gap     [N_PROFILES];

  logic [31:0]          f_start_q;
  logic [31:0]          f_stop_q;
  logic [63:0]          chirp_len_q;
  logic                 start_q;
  logic                 seq_done_q;
  logic [PROF_BITS-1:0] idx_q;
  logic [CNT_WIDTH-1:0] pass_q;
  logic [GAP_WIDTH-1:0] gap_cnt;
  logic                 done_prev;

  logic [PROF_BITS:0]   addr_ext;
  logic                 cfg_ok;
  logic [PROF_BITS:0]   n_eff;
  logic [PROF_BITS:0]   n_last;
  logic [CNT_WIDTH-1:0] pass_nxt;
  logic                 done_rise;

  assign addr_ext  = {1'b0, cfg_addr};
  assign cfg_ok    = cfg_we && (addr_ext < N_PROF_L);
  assign pass_nxt  = pass_q + CNT_WIDTH'(1);
  assign done_rise = dds.dds_done && !done_prev;
  assign n_last    = n_eff - (PROF_BITS + 1)'(1);

  // Clamp the active-profile count into 1..N_PROFILES.
  always_comb begin
    n_eff = n_active;
    if (n_active == '0) begin
      n_eff = (PROF_BITS + 1)'(1);
    end else if (n_active > N_PROF_L) begin
      n_eff = N_PROF_L;
    end
  end

  // Profile table: writable in any state, ignored when the address is out of range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PROFILES; i++) begin
        tbl_f_start[i] <= '0;
        tbl_f_stop[i]  <= '0;
        tbl_len[i]     <= '0;
        tbl_gap[i]     <= '0;
      end
    end else if (cfg_ok) begin
      tbl_f_start[cfg_addr] <= cfg_f_start;
      tbl_f_stop[cfg_addr]  <= cfg_f_stop;
      tbl_len[cfg_addr]     <= cfg_len;
      tbl_gap[cfg_addr]     <= cfg_gap;
    end
  end

  // Previous dds_done, used for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_prev <= 1'b0;
    end else begin
      done_prev <= dds.dds_done;
    end
  end

`ifdef LFM_SEQ_TIMEOUT_EN
  logic [63:0] wd_cnt;
  logic [63:0] wd_nxt;
  logic [64:0] wd_limit;
  logic        timeout_q;

  assign wd_nxt   = wd_cnt + 64'd1;
  assign wd_limit = {1'b0, chirp_len_q} + 65'(TIMEOUT_MARGIN);
  assign timeout  = timeout_q;
`else
  // The margin only matters when the watchdog is built.
  logic [31:0] unused_margin;
  assign unused_margin = 32'(TIMEOUT_MARGIN);
  assign timeout       = 1'b0;
`endif

  // Sequencer FSM: IDLE -> LOAD -> FIRE -> WAIT -> GAP -> (LOAD | IDLE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      f_start_q   <= '0;
      f_stop_q    <= '0;
      chirp_len_q <= '0;
      start_q     <= 1'b0;
      seq_done_q  <= 1'b0;
      idx_q       <= '0;
      pass_q      <= '0;
      gap_cnt     <= '0;
`ifdef LFM_SEQ_TIMEOUT_EN
      wd_cnt      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      start_q    <= 1'b0;
      seq_done_q <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (run && !abort) begin
              state  <= S_LOAD;
              idx_q  <= '0;
              pass_q <= '0;
`ifdef LFM_SEQ_TIMEOUT_EN
              timeout_q <= 1'b0;
`endif
            end
          end
          S_LOAD: begin
            f_start_q   <= tbl_f_start[idx_q];
            f_stop_q    <= tbl_f_stop[idx_q];
            chirp_len_q <= tbl_len[idx_q];
            start_q     <= 1'b1;
            state       <= S_FIRE;
          end
          S_FIRE: begin
            state <= S_WAIT;
`ifdef LFM_SEQ_TIMEOUT_EN
            wd_cnt <= 64'd1;
`endif
          end
          S_WAIT: begin
            if (done_rise) begin
              gap_cnt <= tbl_gap[idx_q];
              state   <= S_GAP;
            end
`ifdef LFM_SEQ_TIMEOUT_EN
            else if ({1'b0, wd_nxt} > wd_limit) begin
              timeout_q <= 1'b1;
              state     <= S_IDLE;
            end else begin
              wd_cnt <= wd_nxt;
            end
`endif
          end
          S_GAP: begin
            if (gap_cnt != '0) begin
              gap_cnt <= gap_cnt - GAP_WIDTH'(1);
            end else if ({1'b0, idx_q} < n_last) begin
              idx_q <= idx_q + PROF_BITS'(1);
              state <= S_LOAD;
            end else begin
              pass_q <= pass_nxt;
              idx_q  <= '0;
              if ((repeat_count != '0) && (pass_nxt == repeat_count)) begin
                seq_done_q <= 1'b1;
                state      <= S_IDLE;
              end else begin
                state <= S_LOAD;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // An abort arriving during FIRE masks the strobe so dds_lfm never samples it.
  assign dds.start     = start_q && !abort;
  assign dds.f_start   = f_start_q;
  assign dds.f_stop    = f_stop_q;
  assign dds.chirp_len = chirp_len_q;
  assign busy          = (state != S_IDLE);
  assign seq_done      = seq_done_q;
  assign profile_idx   = idx_q;
  assign pass_cnt      = pass_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_lfm_chirp_sequencer.sv
// tb_lfm_chirp_sequencer: directed bench for lfm_chirp_sequencer (8-bit pass
// counter build so the infinite-mode wrap is reachable quickly).
`timescale 1ns/1ps
module tb_lfm_chirp_sequencer;
  localparam int CW = 8;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_FIRE = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_addr = '0;
  logic [31:0]   cfg_f_start = '0;
  logic [31:0]   cfg_f_stop = '0;
  logic [63:0]   cfg_len = '0;
  logic [31:0]   cfg_gap = '0;
  logic [2:0]    n_active = 3'd1;
  logic [CW-1:0] repeat_count = '0;
  logic          run = 1'b0;
  logic          abort = 1'b0;
  logic          busy, seq_done, timeout;
  logic [1:0]    profile_idx;
  logic [CW-1:0] pass_cnt;
  logic [2:0]    dbg_state;

  lfm_seq_if dds();

  lfm_chirp_sequencer #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_f_start(cfg_f_start),
    .cfg_f_stop(cfg_f_stop), .cfg_len(cfg_len), .cfg_gap(cfg_gap),
    .n_active(n_active), .repeat_count(repeat_count),
    .run(run), .abort(abort), .dds(dds),
    .busy(busy), .seq_done(seq_done), .profile_idx(profile_idx),
    .pass_cnt(pass_cnt), .timeout(timeout), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  int exp_idx_q[$];
  int exp_sp_q[$];
  bit sb_en = 1'b0;
  bit auto_done = 1'b0;
  int resp_lat = 3;
  int done_timer = 0;
  int start_cnt = 0;
  int seq_cnt = 0;
  int last_done_cyc = 0;
  int last_start_cyc = 0;
  int last_seq_cyc = 0;
  logic busy_at_seq = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample at the falling edge, score starts, then drive the responder.
  task automatic step();
    int sp;
    @(negedge clk);
    if (seq_done) begin
      seq_cnt++;
      last_seq_cyc = cyc;
      busy_at_seq = busy;
    end
    if (dds.start) begin
      start_cnt++;
      last_start_cyc = cyc;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: start at cycle %0d, none expected", cyc);
        end else begin
          check("start_f_start", {32'd0, dds.f_start}, {32'd0, exp_q.pop_front()});
          check("start_profile_idx", {62'd0, profile_idx}, 64'(exp_idx_q.pop_front()));
          sp = exp_sp_q.pop_front();
          if (sp >= 0) check("done_to_start", 64'(cyc - last_done_cyc), 64'(sp));
        end
      end
    end
    if (auto_done) begin
      dds.dds_done = 1'b0;
      if (done_timer > 0) begin
        done_timer--;
        if (done_timer == 0) begin
          dds.dds_done = 1'b1;
          last_done_cyc = cyc;
        end
      end
      if (dds.start) done_timer = resp_lat;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_prof(input logic [1:0] a, input logic [31:0] fs, input logic [31:0] fe,
                            input logic [63:0] len, input logic [31:0] gap);
    cfg_addr = a; cfg_f_start = fs; cfg_f_stop = fe; cfg_len = len; cfg_gap = gap;
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    step();
    run = 1'b0;
  endtask

  task automatic wait_start(input int budget);
    int s0 = start_cnt;
    int n = 0;
    while (start_cnt == s0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (start_cnt == s0) begin
      errors++;
      $display("FAIL start_timeout: no start within %0d cycles", budget);
    end
  endtask

  task automatic run_until_done(input int budget);
    int s0 = seq_cnt;
    int n = 0;
    while (seq_cnt == s0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (seq_cnt == s0) begin
      errors++;
      $display("FAIL seq_done_timeout: no seq_done within %0d cycles", budget);
    end
  endtask

  typedef struct {
    logic [2:0]    n_act;
    logic [CW-1:0] rep;
    int            eff;
    int            exp_starts;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int run_cyc;
    int s0;
    int q0;
    int prev;
    bit wrapped;

    vecs[0] = '{3'd1, 8'd1, 1, 1};
    vecs[1] = '{3'd0, 8'd2, 1, 2};
    vecs[2] = '{3'd3, 8'd1, 3, 3};
    vecs[3] = '{3'd4, 8'd1, 4, 4};
    vecs[4] = '{3'd7, 8'd1, 4, 4};
    vecs[5] = '{3'd2, 8'd3, 2, 6};
    dds.dds_done = 1'b0;

    // ---- reset state ----
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_f_start", {32'd0, dds.f_start}, 64'd0);
    check("rst_f_stop", {32'd0, dds.f_stop}, 64'd0);
    check("rst_chirp_len", dds.chirp_len, 64'd0);
    check("rst_start", {63'd0, dds.start}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_seq_done", {63'd0, seq_done}, 64'd0);
    check("rst_pass_cnt", {56'd0, pass_cnt}, 64'd0);
    check("rst_timeout", {63'd0, timeout}, 64'd0);
    check("rst_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});

    // ---- single chirp ----
    write_prof(2'd0, 32'd10, 32'd1000, 64'd1000, 32'd0);
    n_active = 3'd1; repeat_count = 8'd1;
    auto_done = 1'b1; resp_lat = 3; sb_en = 1'b1;
    exp_q.push_back(32'd10); exp_idx_q.push_back(0); exp_sp_q.push_back(-1);
    run_cyc = cyc;
    run = 1'b1;
    step();
    run = 1'b0;
    check("single_load_state", {61'd0, dbg_state}, {61'd0, ST_LOAD});
    step();
    check("single_start_pulse", {63'd0, dds.start}, 64'd1);
    check("single_f_stop", {32'd0, dds.f_stop}, 64'd1000);
    check("single_chirp_len", dds.chirp_len, 64'd1000);
    run_until_done(50);
    check("single_start_latency", 64'(last_start_cyc - run_cyc), 64'd2);
    check("single_seq_done_timing", 64'(last_seq_cyc - last_done_cyc), 64'd2);
    check("single_busy_at_seq_done", {63'd0, busy_at_seq}, 64'd0);
    check("single_pass_cnt", {56'd0, pass_cnt}, 64'd1);

    // ---- table-driven runs: profile i = {100+i, 200+i, 50, gap i} ----
    for (int i = 0; i < 4; i++) write_prof(2'(i), 32'(100 + i), 32'(200 + i), 64'd50, 32'(i));
    for (int v = 0; v < 6; v++) begin
      n_active = vecs[v].n_act;
      repeat_count = vecs[v].rep;
      start_cnt = 0;
      for (int k = 0; k < vecs[v].exp_starts; k++) begin
        exp_q.push_back(32'(100 + (k % vecs[v].eff)));
        exp_idx_q.push_back(k % vecs[v].eff);
        exp_sp_q.push_back(k == 0 ? -1 : ((k - 1) % vecs[v].eff) + 3);
      end
      pulse_run();
      run_until_done(400);
      check("vec_start_count", 64'(start_cnt), 64'(vecs[v].exp_starts));
      check("vec_pass_cnt", {56'd0, pass_cnt}, {56'd0, vecs[v].rep});
      check("vec_profile_idx_end", {62'd0, profile_idx}, 64'd0);
      check("vec_busy_end", {63'd0, busy}, 64'd0);
      check("vec_queue_empty", 64'(exp_q.size()), 64'd0);
      exp_q.delete(); exp_idx_q.delete(); exp_sp_q.delete();
    end

    // ---- multi-profile gaps {5,0,2}, two passes, run held high while busy ----
    write_prof(2'd0, 32'd300, 32'd400, 64'd20, 32'd5);
    write_prof(2'd1, 32'd301, 32'd401, 64'd20, 32'd0);
    write_prof(2'd2, 32'd302, 32'd402, 64'd20, 32'd2);
    n_active = 3'd3; repeat_count = 8'd2; start_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(32'(300 + (k % 3)));
      exp_idx_q.push_back(k % 3);
    end
    exp_sp_q.push_back(-1); exp_sp_q.push_back(8); exp_sp_q.push_back(3);
    exp_sp_q.push_back(5);  exp_sp_q.push_back(8); exp_sp_q.push_back(3);
    run = 1'b1;
    repeat (6) step();
    run = 1'b0;
    run_until_done(400);
    check("multi_start_count", 64'(start_cnt), 64'd6);
    check("multi_pass_cnt", {56'd0, pass_cnt}, 64'd2);
    check("multi_queue_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete(); exp_idx_q.delete(); exp_sp_q.delete();

    // ---- abort in WAIT ----
    sb_en = 1'b0; auto_done = 1'b0; done_timer = 0; dds.dds_done = 1'b0;
    n_active = 3'd1; repeat_count = 8'd0;
    pulse_run();
    wait_start(10);
    step();
    check("abort_wait_in_wait", {61'd0, dbg_state}, {61'd0, ST_WAIT});
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_wait_busy", {63'd0, busy}, 64'd0);
    check("abort_wait_f_start_held", {32'd0, dds.f_start}, 64'd300);
    s0 = start_cnt; q0 = seq_cnt;
    dds.dds_done = 1'b1;
    step();
    dds.dds_done = 1'b0;
    repeat (10) step();
    check("abort_wait_no_start", 64'(start_cnt), 64'(s0));
    check("abort_wait_no_seq_done", 64'(seq_cnt), 64'(q0));

    // ---- abort in FIRE ----
    s0 = start_cnt;
    pulse_run();
    @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    check("abort_fire_state", {61'd0, dbg_state}, {61'd0, ST_FIRE});
    check("abort_fire_start_masked", {63'd0, dds.start}, 64'd0);
    step();
    abort = 1'b0;
    check("abort_fire_idle", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    repeat (5) step();
    check("abort_fire_no_start", 64'(start_cnt), 64'(s0));

    // ---- run and abort together in IDLE ----
    run = 1'b1; abort = 1'b1;
    step();
    run = 1'b0; abort = 1'b0;
    step();
    check("run_abort_idle", {61'd0, dbg_state}, {61'd0, ST_IDLE});

    // ---- mid-run write to profile 1 ----
    write_prof(2'd0, 32'd500, 32'd510, 64'd30, 32'd0);
    write_prof(2'd1, 32'd600, 32'd610, 64'd30, 32'd0);
    n_active = 3'd2; repeat_count = 8'd1;
    auto_done = 1'b1; resp_lat = 3; sb_en = 1'b1;
    exp_q.push_back(32'd500); exp_idx_q.push_back(0); exp_sp_q.push_back(-1);
    exp_q.push_back(32'd777); exp_idx_q.push_back(1); exp_sp_q.push_back(3);
    pulse_run();
    wait_start(10);
    write_prof(2'd1, 32'd777, 32'd787, 64'd30, 32'd0);
    run_until_done(100);
    check("midwrite_queue_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete(); exp_idx_q.delete(); exp_sp_q.delete();

    // ---- infinite mode: pass_cnt wraps 255 -> 0 and keeps going ----
    sb_en = 1'b0; resp_lat = 1; n_active = 3'd1; repeat_count = 8'd0;
    q0 = seq_cnt; wrapped = 1'b0;
    pulse_run();
    prev = int'(pass_cnt);
    for (int n = 0; n < 3000; n++) begin
      step();
      if (prev == 255 && pass_cnt == 8'd0) begin
        wrapped = 1'b1;
        break;
      end
      prev = int'(pass_cnt);
    end
    check("inf_wrap_seen", {63'd0, wrapped}, 64'd1);
    check("inf_busy_after_wrap", {63'd0, busy}, 64'd1);
    wait_start(10);
    check("inf_no_seq_done", 64'(seq_cnt), 64'(q0));
    abort = 1'b1;
    step();
    abort = 1'b0;
    auto_done = 1'b0; done_timer = 0; dds.dds_done = 1'b0;
    repeat (3) step();

    // ---- reset mid-chirp, dds_done held high across release ----
    n_active = 3'd1; repeat_count = 8'd1;
    pulse_run();
    wait_start(10);
    step();
    dds.dds_done = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_f_start", {32'd0, dds.f_start}, 64'd0);
    check("rstmid_chirp_len", dds.chirp_len, 64'd0);
    check("rstmid_busy", {63'd0, busy}, 64'd0);
    check("rstmid_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("rstmid_idle_after_release", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    pulse_run();
    wait_start(10);
    check("rstmid_table_cleared", {32'd0, dds.f_start}, 64'd0);
    repeat (4) step();
    check("rstmid_held_done_no_gap", {61'd0, dbg_state}, {61'd0, ST_WAIT});
    dds.dds_done = 1'b0;
    step();
    dds.dds_done = 1'b1;
    step();
    check("rstmid_fresh_edge_gap", {61'd0, dbg_state}, {61'd0, ST_GAP});
    dds.dds_done = 1'b0;
    run_until_done(20);
    check("rstmid_pass_cnt", {56'd0, pass_cnt}, 64'd1);

    // ---- report ----
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
